// File: rtl/rename_free_list.sv
`default_nettype none
// ============================================================================
// Module      : rename_free_list
// Description : Multi-port circular free list of physical register tags for
//               the out-of-order rename stage. Up to ALLOC_W tags are handed
//               out per cycle (zero latency) and up to FREE_W tags are taken
//               back per cycle from commit. NUM_CKPT head-pointer checkpoints
//               allow one-cycle recovery of the allocation state on a branch
//               mispredict.
// Options     : FREE_LIST_BYPASS_EN - when defined, tags released this cycle
//               are also offered to allocation after the stored tags.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_free_list #(
    parameter int TAG_W      = 6,
    parameter int DEPTH      = 64,
    parameter int ALLOC_W    = 2,
    parameter int FREE_W     = 2,
    parameter int NUM_CKPT   = 4,
    parameter int INIT_COUNT = 32,
    parameter int INIT_BASE  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ALLOC_W-1:0]          alloc_req,
    output logic                        alloc_ok,
    output logic [ALLOC_W*TAG_W-1:0]    alloc_tag,
    input  logic [FREE_W-1:0]           free_en,
    input  logic [FREE_W*TAG_W-1:0]     free_tag,
    input  logic                        ckpt_save,
    input  logic [$clog2(NUM_CKPT)-1:0] ckpt_id,
    input  logic                        restore,
    input  logic [$clog2(NUM_CKPT)-1:0] restore_id,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty,
    output logic                        full,
    output logic                        err_ovf
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one extra wrap bit so that full and empty are distinct.
    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t c_depth      = ptr_t'(DEPTH);
    localparam ptr_t c_init_count = ptr_t'(INIT_COUNT);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [TAG_W-1:0] r_fifo [DEPTH];
    ptr_t             r_head;
    ptr_t             r_tail;
    ptr_t             r_ckpt [NUM_CKPT];
    logic             r_err_ovf;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    ptr_t             w_count;
    ptr_t             w_alloc_rank [ALLOC_W];
    ptr_t             w_alloc_n;
    ptr_t             w_free_rank [FREE_W];
    ptr_t             w_free_m;
    ptr_t             w_take;       // tags taken from storage this cycle
    ptr_t             w_byp;        // released tags consumed directly by allocation
    ptr_t             w_rel_left;   // released tags that still need a slot
    ptr_t             w_space;      // free slots left after this cycle's allocation
    ptr_t             w_wr_n;       // released tags actually written
    logic             w_drop;
    logic [FREE_W-1:0] w_wr_en;
    logic [IDX_W-1:0] w_wr_idx [FREE_W];
    logic [IDX_W-1:0] w_rd_idx [ALLOC_W];
    ptr_t             w_head_nxt;
    ptr_t             w_tail_nxt;

    // Occupancy is always derived from the registered pointers.
    assign w_count = r_tail - r_head;
    assign count   = w_count;
    assign empty   = (w_count == '0);
    assign full    = (w_count == c_depth);
    assign err_ovf = r_err_ovf;

    // Rank of each requesting lane among the requesting lanes below it, and the total.
    always_comb begin : p_alloc_rank
        ptr_t w_run;
        w_run = '0;
        for (int k = 0; k < ALLOC_W; k++) begin
            w_alloc_rank[k] = w_run;
            if (alloc_req[k]) begin
                w_run = w_run + ptr_t'(1);
            end
        end
        w_alloc_n = w_run;
    end

    // Compaction rank of each releasing lane, and the number of releases.
    always_comb begin : p_free_rank
        ptr_t w_run;
        w_run = '0;
        for (int l = 0; l < FREE_W; l++) begin
            w_free_rank[l] = w_run;
            if (free_en[l]) begin
                w_run = w_run + ptr_t'(1);
            end
        end
        w_free_m = w_run;
    end

`ifdef FREE_LIST_BYPASS_EN
    logic [TAG_W-1:0] w_rel_tag [FREE_W];

    // Released tags packed in lane order so allocation can index them by rank.
    always_comb begin : p_rel_compact
        for (int j = 0; j < FREE_W; j++) begin
            w_rel_tag[j] = '0;
        end
        for (int l = 0; l < FREE_W; l++) begin
            for (int j = 0; j < FREE_W; j++) begin
                if (free_en[l] && (w_free_rank[l] == ptr_t'(j))) begin
                    w_rel_tag[j] = free_tag[l*TAG_W +: TAG_W];
                end
            end
        end
    end

    // All-or-nothing grant; stored tags are used first, then this cycle's releases.
    always_comb begin : p_alloc_ctl
        alloc_ok = (({1'b0, w_count} + {1'b0, w_free_m}) >= {1'b0, w_alloc_n}) && !restore;
        w_take   = '0;
        w_byp    = '0;
        if (alloc_ok) begin
            if (w_alloc_n > w_count) begin
                w_take = w_count;
                w_byp  = w_alloc_n - w_count;
            end else begin
                w_take = w_alloc_n;
            end
        end
    end
`else
    // All-or-nothing grant from stored tags only; releases are not visible yet.
    always_comb begin : p_alloc_ctl
        alloc_ok = (w_count >= w_alloc_n) && !restore;
        w_take   = alloc_ok ? w_alloc_n : '0;
        w_byp    = '0;
    end
`endif

    // Per-lane tag lookup at head + rank (plus the bypass path when enabled).
    always_comb begin : p_alloc_tag
        alloc_tag = '0;
        for (int k = 0; k < ALLOC_W; k++) begin
            w_rd_idx[k] = IDX_W'(r_head + w_alloc_rank[k]);
            alloc_tag[k*TAG_W +: TAG_W] = r_fifo[w_rd_idx[k]];
`ifdef FREE_LIST_BYPASS_EN
            if (w_alloc_rank[k] >= w_count) begin
                for (int j = 0; j < FREE_W; j++) begin
                    if ((w_alloc_rank[k] - w_count) == ptr_t'(j)) begin
                        alloc_tag[k*TAG_W +: TAG_W] = w_rel_tag[j];
                    end
                end
            end
`endif
        end
    end

    // Limit writes to the space left after allocation; excess high lanes are dropped.
    always_comb begin : p_release_ctl
        w_rel_left = w_free_m - w_byp;
        w_space    = c_depth - (w_count - w_take);
        if (w_rel_left > w_space) begin
            w_wr_n = w_space;
            w_drop = 1'b1;
        end else begin
            w_wr_n = w_rel_left;
            w_drop = 1'b0;
        end
    end

    // Per-lane write enable and slot, skipping bypassed ranks and dropped ranks.
    always_comb begin : p_release_lane
        for (int l = 0; l < FREE_W; l++) begin
            w_wr_en[l]  = free_en[l]
                        && (w_free_rank[l] >= w_byp)
                        && (w_free_rank[l] < (w_byp + w_wr_n));
            w_wr_idx[l] = IDX_W'(r_tail + w_free_rank[l] - w_byp);
        end
    end

    // Next pointers: restore overrides allocation; tail is never checkpointed.
    always_comb begin : p_ptr_nxt
        w_head_nxt = restore ? r_ckpt[restore_id] : (r_head + w_take);
        w_tail_nxt = r_tail + w_wr_n;
    end

    // Pointer, checkpoint and sticky overflow state.
    always_ff @(posedge clk or negedge rst_n) begin : p_ctl_regs
        if (!rst_n) begin
            r_head    <= '0;
            r_tail    <= c_init_count;
            r_err_ovf <= 1'b0;
            for (int i = 0; i < NUM_CKPT; i++) begin
                r_ckpt[i] <= '0;
            end
        end else begin
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
            // A save alongside a restore captures the restored head.
            if (ckpt_save) begin
                r_ckpt[ckpt_id] <= w_head_nxt;
            end
            if (w_drop) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    // Tag storage: preloaded with the initial free tags, then written by releases.
    always_ff @(posedge clk or negedge rst_n) begin : p_fifo
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= (i < INIT_COUNT) ? TAG_W'(INIT_BASE + i) : '0;
            end
        end else begin
            for (int l = 0; l < FREE_W; l++) begin
                if (w_wr_en[l]) begin
                    r_fifo[w_wr_idx[l]] <= free_tag[l*TAG_W +: TAG_W];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rename_free_list.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_free_list
// Description : Self-checking bench for rename_free_list with a queue/array
//               reference model, directed scenarios and randomized traffic.
//               Honours FREE_LIST_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_free_list;

    localparam int TAG_W      = 6;
    localparam int DEPTH      = 64;
    localparam int ALLOC_W    = 2;
    localparam int FREE_W     = 2;
    localparam int NUM_CKPT   = 4;
    localparam int INIT_COUNT = 32;
    localparam int INIT_BASE  = 32;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [ALLOC_W-1:0]       alloc_req;
    logic                     alloc_ok;
    logic [ALLOC_W*TAG_W-1:0] alloc_tag;
    logic [FREE_W-1:0]        free_en;
    logic [FREE_W*TAG_W-1:0]  free_tag;
    logic                     ckpt_save;
    logic [1:0]               ckpt_id;
    logic                     restore;
    logic [1:0]               restore_id;
    logic [6:0]               count;
    logic                     empty;
    logic                     full;
    logic                     err_ovf;

    always #5 clk = ~clk;

    rename_free_list #(
        .TAG_W(TAG_W), .DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .FREE_W(FREE_W),
        .NUM_CKPT(NUM_CKPT), .INIT_COUNT(INIT_COUNT), .INIT_BASE(INIT_BASE)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_ok(alloc_ok), .alloc_tag(alloc_tag),
        .free_en(free_en), .free_tag(free_tag),
        .ckpt_save(ckpt_save), .ckpt_id(ckpt_id),
        .restore(restore), .restore_id(restore_id),
        .count(count), .empty(empty), .full(full), .err_ovf(err_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: unbounded integer pointers over a DEPTH-entry array.
    int m_mem [DEPTH];
    int m_head;
    int m_tail;
    int m_slot [NUM_CKPT];
    bit m_err;

    // Last observed allocation result (captured from the DUT for directed checks).
    bit obs_ok;
    int obs_tag [ALLOC_W];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = (i < INIT_COUNT) ? INIT_BASE + i : 0;
        m_head = 0;
        m_tail = INIT_COUNT;
        for (int i = 0; i < NUM_CKPT; i++) m_slot[i] = 0;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alloc_req = '0; free_en = '0; free_tag = '0;
        ckpt_save = 1'b0; ckpt_id = '0; restore = 1'b0; restore_id = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk("reset_count", 32'(count), 32'(INIT_COUNT));
        chk("reset_empty", 32'(empty), 0);
        chk("reset_full",  32'(full), 0);
        chk("reset_err",   32'(err_ovf), 0);
    endtask

    // One clock: drive, check outputs at the falling edge, advance the model.
    task automatic cyc(input logic [1:0] areq, input logic [1:0] fen,
                       input int ft0, input int ft1,
                       input logic sv, input int sid,
                       input logic rs, input int rid);
        int rel [$];
        int cnt, n, avail, rank, take, byp, space, written;
        bit e_ok;
        int e_tag [ALLOC_W];

        alloc_req  = areq;
        free_en    = fen;
        free_tag   = {TAG_W'(ft1), TAG_W'(ft0)};
        ckpt_save  = sv;
        ckpt_id    = 2'(sid);
        restore    = rs;
        restore_id = 2'(rid);

        cnt = m_tail - m_head;
        if (fen[0]) rel.push_back(ft0);
        if (fen[1]) rel.push_back(ft1);
        n = int'(areq[0]) + int'(areq[1]);
        avail = cnt;
`ifdef FREE_LIST_BYPASS_EN
        avail = cnt + rel.size();
`endif
        e_ok = (avail >= n) && !rs;
        rank = 0;
        for (int k = 0; k < ALLOC_W; k++) begin
            e_tag[k] = 0;
            if (areq[k]) begin
                if (rank < cnt) e_tag[k] = m_mem[(m_head + rank) % DEPTH];
                else            e_tag[k] = rel[rank - cnt];
                rank++;
            end
        end

        @(negedge clk);
        obs_ok = alloc_ok;
        for (int k = 0; k < ALLOC_W; k++) obs_tag[k] = int'(alloc_tag[k*TAG_W +: TAG_W]);
        chk("count", 32'(count), 32'(cnt));
        chk("empty", 32'(empty), 32'(cnt == 0));
        chk("full",  32'(full),  32'(cnt == DEPTH));
        chk("err_ovf", 32'(err_ovf), 32'(m_err));
        chk("alloc_ok", 32'(alloc_ok), 32'(e_ok));
        if (e_ok) begin
            for (int k = 0; k < ALLOC_W; k++) begin
                if (areq[k]) chk($sformatf("alloc_tag%0d", k), 32'(obs_tag[k]), 32'(e_tag[k]));
            end
        end

        @(posedge clk);
        take = 0;
        byp  = 0;
        if (e_ok) begin
            take = (n < cnt) ? n : cnt;
            byp  = n - take;
        end
        m_head += take;
        space = DEPTH - (cnt - take);
        written = 0;
        for (int j = byp; j < rel.size(); j++) begin
            if (written < space) begin
                m_mem[m_tail % DEPTH] = rel[j];
                m_tail++;
                written++;
            end else begin
                m_err = 1'b1;
            end
        end
        if (rs) m_head = m_slot[rid];
        if (sv) m_slot[sid] = m_head;
        #1;
    endtask

    initial begin
        int first_tags [2];
        int out_q [$];
        int dups;

        // Basic two-lane allocation after reset.
        do_reset();
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("first_ok", 32'(obs_ok), 1);
        chk("first_lane0", 32'(obs_tag[0]), 32);
        chk("first_lane1", 32'(obs_tag[1]), 33);
        chk("first_count_after", 32'(count), 30);

        // Upper lane alone gets the head tag, then drain to one.
        do_reset();
        cyc(2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("upper_lane_tag", 32'(obs_tag[1]), 32);
        for (int i = 0; i < 15; i++) cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("drain_count", 32'(count), 1);
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("short_ok", 32'(obs_ok), 0);
        chk("short_count", 32'(count), 1);

        // Checkpoint, allocate six, restore, and re-allocate the same tags.
        do_reset();
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc(2'b00, 2'b00, 0, 0, 1, 1, 0, 0);
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        first_tags[0] = obs_tag[0];
        first_tags[1] = obs_tag[1];
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("pre_restore_count", 32'(count), 24);
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 1, 1);
        chk("restore_ok", 32'(obs_ok), 0);
        chk("restore_count", 32'(count), 30);
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("replay_lane0", 32'(obs_tag[0]), 32'(first_tags[0]));
        chk("replay_lane1", 32'(obs_tag[1]), 32'(first_tags[1]));

        // Fill to DEPTH, then overflow.
        do_reset();
        for (int i = 0; i < 16; i++) cyc(2'b00, 2'b11, 2*i, 2*i+1, 0, 0, 0, 0);
        chk("fill_full", 32'(full), 1);
        cyc(2'b00, 2'b11, 5, 6, 0, 0, 0, 0);
        chk("ovf_err", 32'(err_ovf), 1);
        chk("ovf_count", 32'(count), 64);

        // Empty list with a same-cycle release.
        do_reset();
        for (int i = 0; i < 16; i++) cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("drained_empty", 32'(empty), 1);
        cyc(2'b01, 2'b01, 7, 0, 0, 0, 0, 0);
`ifdef FREE_LIST_BYPASS_EN
        chk("bypass_ok", 32'(obs_ok), 1);
        chk("bypass_tag", 32'(obs_tag[0]), 7);
        chk("bypass_count", 32'(count), 0);
`else
        chk("nobypass_ok", 32'(obs_ok), 0);
        chk("nobypass_count", 32'(count), 1);
`endif

        // Steady recirculation: tags 0..31 are in flight, two out and two back per cycle.
        do_reset();
        for (int i = 0; i < INIT_COUNT; i++) out_q.push_back(i);
        dups = 0;
        for (int c = 0; c < 200; c++) begin
            cyc(2'b11, 2'b11, out_q[0], out_q[1], 0, 0, 0, 0);
            if (obs_tag[0] == obs_tag[1]) dups++;
            for (int j = 0; j < out_q.size(); j++) begin
                if (out_q[j] == obs_tag[0] || out_q[j] == obs_tag[1]) dups++;
            end
            void'(out_q.pop_front());
            void'(out_q.pop_front());
            out_q.push_back(obs_tag[0]);
            out_q.push_back(obs_tag[1]);
        end
        chk("steady_count", 32'(count), 32);
        chk("steady_dups", 32'(dups), 0);

        // Randomized traffic with legal checkpoint restores.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] areq, fen;
            logic sv, rs;
            int sid, rid;
            areq = 2'($urandom_range(0, 3));
            fen  = 2'($urandom_range(0, 3));
            sv   = ($urandom_range(0, 7) == 0);
            sid  = $urandom_range(0, NUM_CKPT-1);
            rid  = $urandom_range(0, NUM_CKPT-1);
            rs   = ($urandom_range(0, 15) == 0)
                && (m_slot[rid] <= m_head)
                && (m_tail + FREE_W - m_slot[rid] <= DEPTH);
            cyc(areq, fen, $urandom_range(0, 63), $urandom_range(0, 63), sv, sid, rs, rid);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
